neander_ctrl: RTL and testbench
===============================

NEANDER_CTRL -- requirements
Module: neander_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: opcode  input  4  instruction opcode, RI[15:12], valid from the cycle after carga_ri.
REQ-004 SHALL have port: N, Z  input  1 each  registered negative/zero flags from the NZ register.
REQ-005 SHALL have port: selULA  output  3  ULA op: 000 ADD, 001 OR, 010 AND, 011 NOT, 100 pass X.
REQ-006 SHALL have port: sel_ac  output  1  AC source: 0 ULA result, 1 RDM.
REQ-007 SHALL have port: sel_rem  output  1  REM source: 0 PC, 1 RDM.
REQ-008 SHALL have port: sel_rdm  output  1  RDM source: 0 memory read data, 1 AC.
REQ-009 SHALL have ports: carga_ac, carga_nz, carga_pc, inc_pc, carga_rem, carga_rdm, carga_ri  output  1 each  register load/increment strobes.
REQ-010 SHALL have ports: mem_rd, mem_wr  output  1 each  memory read (combinational, data valid same cycle) / write at address REM.
REQ-011 SHALL have port: halted  output  1  high while in HALT state.

Function
REQ-012 SHALL be a Moore FSM; every output a pure function of current state; N, Z, opcode affect only next state.
REQ-013 SHALL use states: F0, F1, F2, DEC, OP0, OP1, OP2, LD0, LD1, ST0, ST1, SKIP, JP, HALT.
REQ-014 F0: carga_rem, sel_rem=0 -> F1.
REQ-015 F1: mem_rd, carga_rdm, sel_rdm=0, inc_pc -> F2.
REQ-016 F2: carga_ri -> DEC.
REQ-017 DEC (no strobes) SHALL branch on opcode: 0000 NOP -> F0; 0001 STA, 0010 LDA, 0011 ADD, 0100 OR, 0101 AND -> OP0; 0110 NOT -> LD1; 1000 JMP -> OP0; 1001 JN -> OP0 if N=1 else SKIP; 1010 JZ -> OP0 if Z=1 else SKIP; 1111 HLT -> HALT; all other opcodes -> F0 (NOP).
REQ-018 OP0: carga_rem, sel_rem=0 -> OP1.
REQ-019 OP1: mem_rd, carga_rdm, sel_rdm=0, inc_pc -> JP for jumps, else OP2.
REQ-020 OP2: carga_rem, sel_rem=1 -> ST0 for STA, else LD0.
REQ-021 LD0: mem_rd, carga_rdm, sel_rdm=0 -> LD1.
REQ-022 LD1: carga_ac, carga_nz; LDA sel_ac=1; ADD selULA=000, OR 001, AND 010, NOT 011, all with sel_ac=0 -> F0.
REQ-023 ST0: carga_rdm, sel_rdm=1 -> ST1; ST1: mem_wr -> F0; carga_ac and carga_nz SHALL stay low for STA.
REQ-024 JP: carga_pc (PC <- RDM) -> F0.
REQ-025 SKIP: inc_pc (skip operand word) -> F0.
REQ-026 HALT: halted=1, all strobes low, remain until rst.
REQ-027 Opcode SHALL be sampled only in DEC; the decoded instruction SHALL be held in an internal register for use in OP1..LD1 (opcode input may change after DEC).
REQ-028 In every non-listed cycle all strobes SHALL be 0, selULA=100, sel_ac/sel_rem/sel_rdm=0.
REQ-029 mem_rd and mem_wr SHALL never be high in the same cycle; at most one of carga_pc/inc_pc high per cycle.
REQ-030 Cycle counts (F0 to next F0): NOP/undefined 4, NOT 5, jump not taken 5, JMP/taken 7, LDA/ADD/OR/AND/STA 9.

Reset
REQ-031 rst high at a rising edge SHALL force state F0 from any state, including mid-instruction and HALT; no partial memory write issued after reset.
REQ-032 While in reset-entered F0 the outputs SHALL be F0 values; all strobes other than carga_rem SHALL be 0, halted=0.

Verification
REQ-033 Reset then opcode=0010 (LDA): strobe sequence F0..LD1 over 9 cycles, LD1 shows carga_ac=1, sel_ac=1, carga_nz=1, then F0.
REQ-034 opcode=0011 (ADD): LD1 selULA=000, sel_ac=0; opcode=0110 (NOT): 5 cycles, selULA=011, no mem_rd after F1.
REQ-035 opcode=0001 (STA): ST0 carga_rdm with sel_rdm=1, ST1 mem_wr=1, carga_ac never asserted; 9 cycles.
REQ-036 opcode=1001 with N=0: SKIP inc_pc once, 5 cycles; with N=1: carga_pc in cycle 7; same for 1010 with Z.
REQ-037 opcode=1111: halted=1 indefinitely, no strobes; rst pulse -> F0, halted=0, fetch resumes.
REQ-038 rst asserted during ST0: next cycle F0, mem_wr never asserted for that instruction.

Source files
------------

// File: rtl/neander_ctrl.sv
// Neander control unit: Moore FSM sequencing fetch, decode and execute strobes
// for the Neander datapath (AC, NZ, PC, REM, RDM, RI, ULA, memory).
module neander_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       N,
    input  logic       Z,
    output logic [2:0] selULA,
    output logic       sel_ac,
    output logic       sel_rem,
    output logic       sel_rdm,
    output logic       carga_ac,
    output logic       carga_nz,
    output logic       carga_pc,
    output logic       inc_pc,
    output logic       carga_rem,
    output logic       carga_rdm,
    output logic       carga_ri,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       halted
);

    typedef enum logic [3:0] {
        F0, F1, F2, DEC, OP0, OP1, OP2, LD0, LD1, ST0, ST1, SKIP, JP, HALT
    } state_t;

    state_t     state, state_nx;
    logic [3:0] op_q;

    // Opcode is captured on leaving DEC; execute states only look at op_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= F0;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == DEC)
                op_q <= opcode;
        end
    end

    always_comb begin
        state_nx  = state;
        selULA    = 3'b100;
        sel_ac    = 1'b0;
        sel_rem   = 1'b0;
        sel_rdm   = 1'b0;
        carga_ac  = 1'b0;
        carga_nz  = 1'b0;
        carga_pc  = 1'b0;
        inc_pc    = 1'b0;
        carga_rem = 1'b0;
        carga_rdm = 1'b0;
        carga_ri  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        halted    = 1'b0;

        unique case (state)
            F0: begin
                carga_rem = 1'b1;
                state_nx  = F1;
            end
            F1: begin
                mem_rd    = 1'b1;
                carga_rdm = 1'b1;
                inc_pc    = 1'b1;
                state_nx  = F2;
            end
            F2: begin
                carga_ri = 1'b1;
                state_nx = DEC;
            end
            DEC: begin
                case (opcode)
                    4'b0001, 4'b0010, 4'b0011,
                    4'b0100, 4'b0101, 4'b1000: state_nx = OP0;
                    4'b0110:                   state_nx = LD1;
                    4'b1001:                   state_nx = N ? OP0 : SKIP;
                    4'b1010:                   state_nx = Z ? OP0 : SKIP;
                    4'b1111:                   state_nx = HALT;
                    default:                   state_nx = F0;
                endcase
            end
            OP0: begin
                carga_rem = 1'b1;
                state_nx  = OP1;
            end
            OP1: begin
                mem_rd    = 1'b1;
                carga_rdm = 1'b1;
                inc_pc    = 1'b1;
                state_nx  = (op_q[3:2] == 2'b10) ? JP : OP2;
            end
            OP2: begin
                carga_rem = 1'b1;
                sel_rem   = 1'b1;
                state_nx  = (op_q == 4'b0001) ? ST0 : LD0;
            end
            LD0: begin
                mem_rd    = 1'b1;
                carga_rdm = 1'b1;
                state_nx  = LD1;
            end
            LD1: begin
                carga_ac = 1'b1;
                carga_nz = 1'b1;
                case (op_q)
                    4'b0010: sel_ac = 1'b1;
                    4'b0011: selULA = 3'b000;
                    4'b0100: selULA = 3'b001;
                    4'b0101: selULA = 3'b010;
                    4'b0110: selULA = 3'b011;
                    default: ;
                endcase
                state_nx = F0;
            end
            ST0: begin
                carga_rdm = 1'b1;
                sel_rdm   = 1'b1;
                state_nx  = ST1;
            end
            ST1: begin
                mem_wr   = 1'b1;
                state_nx = F0;
            end
            SKIP: begin
                inc_pc   = 1'b1;
                state_nx = F0;
            end
            JP: begin
                carga_pc = 1'b1;
                state_nx = F0;
            end
            HALT: begin
                halted   = 1'b1;
                state_nx = HALT;
            end
            default: state_nx = F0;
        endcase
    end

endmodule

// File: tb/tb_neander_ctrl.sv
// Bench for neander_ctrl: per-instruction expected output streams built from
// a cycle-by-cycle micro-operation table, compared with the DUT every cycle.
module tb_neander_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       N, Z;
    logic [2:0] selULA;
    logic       sel_ac, sel_rem, sel_rdm;
    logic       carga_ac, carga_nz, carga_pc, inc_pc;
    logic       carga_rem, carga_rdm, carga_ri;
    logic       mem_rd, mem_wr, halted;

    int errors = 0;
    int checks = 0;

    neander_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .N(N), .Z(Z),
        .selULA(selULA), .sel_ac(sel_ac), .sel_rem(sel_rem), .sel_rdm(sel_rdm),
        .carga_ac(carga_ac), .carga_nz(carga_nz), .carga_pc(carga_pc),
        .inc_pc(inc_pc), .carga_rem(carga_rem), .carga_rdm(carga_rdm),
        .carga_ri(carga_ri), .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {selULA, sel_ac, sel_rem, sel_rdm, carga_ac, carga_nz, carga_pc,
                  inc_pc, carga_rem, carga_rdm, carga_ri, mem_rd, mem_wr, halted};

    // Field masks in the packed observation vector.
    localparam logic [15:0] IDLE    = 16'h8000;  // selULA=100, everything else low
    localparam logic [15:0] B_SELAC = 16'h1000;
    localparam logic [15:0] B_SELRM = 16'h0800;
    localparam logic [15:0] B_SELRD = 16'h0400;
    localparam logic [15:0] B_CAC   = 16'h0200;
    localparam logic [15:0] B_CNZ   = 16'h0100;
    localparam logic [15:0] B_CPC   = 16'h0080;
    localparam logic [15:0] B_INC   = 16'h0040;
    localparam logic [15:0] B_CREM  = 16'h0020;
    localparam logic [15:0] B_CRDM  = 16'h0010;
    localparam logic [15:0] B_CRI   = 16'h0008;
    localparam logic [15:0] B_RD    = 16'h0004;
    localparam logic [15:0] B_WR    = 16'h0002;
    localparam logic [15:0] B_HLT   = 16'h0001;

    localparam logic [15:0] U_REM_PC   = IDLE | B_CREM;
    localparam logic [15:0] U_READ_INC = IDLE | B_RD | B_CRDM | B_INC;
    localparam logic [15:0] U_LOAD_RI  = IDLE | B_CRI;
    localparam logic [15:0] U_REM_RDM  = IDLE | B_CREM | B_SELRM;
    localparam logic [15:0] U_READ     = IDLE | B_RD | B_CRDM;
    localparam logic [15:0] U_RDM_AC   = IDLE | B_CRDM | B_SELRD;
    localparam logic [15:0] U_WRITE    = IDLE | B_WR;
    localparam logic [15:0] U_LOAD_PC  = IDLE | B_CPC;
    localparam logic [15:0] U_SKIP     = IDLE | B_INC;
    localparam logic [15:0] U_HALT     = IDLE | B_HLT;

    logic [15:0] expq[$];

    function automatic logic [15:0] acc(input logic [2:0] ula, input logic from_rdm);
        return {ula, 13'b0} | B_CAC | B_CNZ | (from_rdm ? B_SELAC : 16'h0000);
    endfunction

    // Expected per-cycle outputs from F0 up to (not including) the next F0.
    task automatic build(input logic [3:0] op, input logic n, input logic z, input int halt_cycles);
        expq = '{U_REM_PC, U_READ_INC, U_LOAD_RI, IDLE};
        case (op)
            4'h1: expq = {expq, U_REM_PC, U_READ_INC, U_REM_RDM, U_RDM_AC, U_WRITE};
            4'h2: expq = {expq, U_REM_PC, U_READ_INC, U_REM_RDM, U_READ, acc(3'b100, 1'b1)};
            4'h3: expq = {expq, U_REM_PC, U_READ_INC, U_REM_RDM, U_READ, acc(3'b000, 1'b0)};
            4'h4: expq = {expq, U_REM_PC, U_READ_INC, U_REM_RDM, U_READ, acc(3'b001, 1'b0)};
            4'h5: expq = {expq, U_REM_PC, U_READ_INC, U_REM_RDM, U_READ, acc(3'b010, 1'b0)};
            4'h6: expq.push_back(acc(3'b011, 1'b0));
            4'h8: expq = {expq, U_REM_PC, U_READ_INC, U_LOAD_PC};
            4'h9: if (n) expq = {expq, U_REM_PC, U_READ_INC, U_LOAD_PC};
                  else   expq.push_back(U_SKIP);
            4'hA: if (z) expq = {expq, U_REM_PC, U_READ_INC, U_LOAD_PC};
                  else   expq.push_back(U_SKIP);
            4'hF: for (int i = 0; i < halt_cycles; i++) expq.push_back(U_HALT);
            default: ;
        endcase
    endtask

    // Entered at a negedge inside F0; leaves at a negedge inside the next F0.
    // The real opcode/N/Z are presented only during DEC; other cycles get noise.
    // stop_at >= 0 raises rst after checking that cycle and returns one edge later.
    task automatic drive_instr(input string name, input logic [3:0] op, input logic n,
                               input logic z, input int stop_at);
        build(op, n, z, 8);
        for (int k = 0; k < expq.size(); k++) begin
            checks++;
            if (obs !== expq[k]) begin
                errors++;
                $display("FAIL %s op=%b n=%b z=%b cyc%0d: got %h want %h",
                         name, op, n, z, k, obs, expq[k]);
            end
            checks++;
            if (((mem_rd & mem_wr) | (carga_pc & inc_pc)) !== 1'b0) begin
                errors++;
                $display("FAIL %s_excl cyc%0d: rd=%b wr=%b cpc=%b inc=%b want no overlap",
                         name, k, mem_rd, mem_wr, carga_pc, inc_pc);
            end
            if (k == stop_at) begin
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            opcode = (k == 3) ? op : 4'($urandom);
            N      = (k == 3) ? n  : 1'($urandom);
            Z      = (k == 3) ? z  : 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic check_f0(input string name);
        checks++;
        if (obs !== U_REM_PC) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, obs, U_REM_PC);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_f0("reset_f0");
        rst = 1'b0;
    endtask

    task automatic test_lda;
        drive_instr("lda", 4'b0010, 1'b0, 1'b0, -1);
        check_f0("lda_return_f0");
    endtask

    task automatic test_alu;
        drive_instr("add", 4'b0011, 1'b1, 1'b0, -1);
        drive_instr("or",  4'b0100, 1'b0, 1'b1, -1);
        drive_instr("and", 4'b0101, 1'b1, 1'b1, -1);
        drive_instr("not", 4'b0110, 1'b0, 1'b0, -1);
        check_f0("not_return_f0");
    endtask

    task automatic test_sta;
        drive_instr("sta", 4'b0001, 1'b1, 1'b1, -1);
        check_f0("sta_return_f0");
    endtask

    task automatic test_jumps;
        drive_instr("jmp",    4'b1000, 1'b0, 1'b0, -1);
        drive_instr("jn_nt",  4'b1001, 1'b0, 1'b1, -1);
        drive_instr("jn_tk",  4'b1001, 1'b1, 1'b0, -1);
        drive_instr("jz_nt",  4'b1010, 1'b1, 1'b0, -1);
        drive_instr("jz_tk",  4'b1010, 1'b0, 1'b1, -1);
        drive_instr("nop",    4'b0000, 1'b0, 1'b0, -1);
        drive_instr("undef7", 4'b0111, 1'b1, 1'b1, -1);
        drive_instr("undefe", 4'b1110, 1'b0, 1'b0, -1);
        check_f0("jumps_return_f0");
    endtask

    task automatic test_halt;
        drive_instr("hlt", 4'b1111, 1'b0, 1'b0, -1);
        test_reset();
        drive_instr("after_hlt_lda", 4'b0010, 1'b0, 1'b0, -1);
        check_f0("after_hlt_f0");
    endtask

    task automatic test_reset_mid_store;
        drive_instr("sta_cut", 4'b0001, 1'b0, 1'b0, 7);
        check_f0("sta_cut_f0");
        rst = 1'b0;
        drive_instr("after_cut_sta", 4'b0001, 1'b0, 1'b0, -1);
        check_f0("after_cut_f0");
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            drive_instr("rand", 4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), -1);
        end
        check_f0("rand_return_f0");
    endtask

    initial begin
        rst    = 1'b1;
        opcode = '0;
        N      = 1'b0;
        Z      = 1'b0;
        test_reset();
        test_lda();
        test_alu();
        test_sta();
        test_jumps();
        test_halt();
        test_reset_mid_store();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
